// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: sequential binary-to-BCD converter (shift-and-add-3).
// Converts an IN_W-bit unsigned value (IN_W <= 20) into six packed BCD digits.
// Each conversion takes IN_W shift cycles plus one output cycle.
// Optional build macro OVF_CLAMP_EN: when defined, values >= 1_000_000
// report bcd_out = 24'h999999. Otherwise they report the low six digits.
// In both builds ovf flags values >= 1_000_000.
module bin2bcd_seq #(
  parameter int IN_W = 20
) (
  input  logic            sys_clk,
  input  logic            sys_rst,
  input  logic [IN_W-1:0] in_data,
  input  logic            in_valid,
  output logic            in_ready,
  output logic [23:0]     bcd_out,
  output logic            ovf,
  output logic            out_valid
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  localparam logic [4:0] LAST = 5'(IN_W - 1);

  state_t      state;
  logic [19:0] bin_sr;   // binary operand, MSB taken from bit IN_W-1
  logic [27:0] acc;      // seven BCD digits
  logic [26:0] acc_adj;  // digits after the +3 correction, minus the top bit
  logic [4:0]  cnt;

  assign in_ready = (state == IDLE);

  // Add 3 to every digit >= 5 ahead of the shift. Operands stay below 2^20,
  // so the top digit never exceeds 1 and needs no correction. Its upper bit
  // is shifted out and dropped.
  always_comb begin
    acc_adj = acc[26:0];
    for (int d = 0; d < 6; d++) begin
      if (acc[4*d +: 4] >= 4'd5)
        acc_adj[4*d +: 4] = acc[4*d +: 4] + 4'd3;
    end
  end

  // Conversion FSM: capture, IN_W correction+shift steps, then publish.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state     <= IDLE;
      bin_sr    <= '0;
      acc       <= '0;
      cnt       <= '0;
      bcd_out   <= '0;
      ovf       <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (in_valid) begin
            bin_sr <= 20'(in_data);
            acc    <= '0;
            cnt    <= '0;
            state  <= SHIFT;
          end
        end
        SHIFT: begin
          acc    <= {acc_adj, bin_sr[IN_W-1]};
          bin_sr <= {bin_sr[18:0], 1'b0};
          cnt    <= cnt + 5'd1;
          if (cnt == LAST) state <= DONE;
        end
        DONE: begin
          state     <= IDLE;
          out_valid <= 1'b1;
          // A nonzero seventh digit means the value is at least 1_000_000.
          ovf       <= (acc[27:24] != 4'd0);
`ifdef OVF_CLAMP_EN
          bcd_out   <= (acc[27:24] != 4'd0) ? 24'h999999 : acc[23:0];
`else
          bcd_out   <= acc[23:0];
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
